// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter. Sends one DATA_BITS word per
//                request as start bit, data LSB first, optional odd/even
//                parity and one or two stop bits, with a baud divider and a
//                busy/done handshake. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY       = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    // Baud counter width is max(1, clog2(CLKS_PER_BIT)).
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] C_CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             C_STOP_LAST = (STOP_BITS == 2);

    // Elaboration-time rejection of unsupported configurations.
    generate
        if ((PARITY < 0) || (PARITY > 2) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
            (CLKS_PER_BIT < 1) || (DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_params
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_n;
    logic [CNT_W-1:0]     r_cnt;
    logic [CNT_W-1:0]     w_cnt_n;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_n;
    logic                 r_stop;
    logic                 w_stop_n;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_n;
    logic                 r_par;
    logic                 w_par_n;
    logic                 w_tx_n;
    logic                 w_busy_n;
    logic                 w_done_n;
    logic                 w_bit_end;

    // Next-state, counter and shifter logic; outputs are derived from the next state
    // so that tx/busy/done come straight out of flops.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_idx_n   = r_idx;
        w_stop_n  = r_stop;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_tx_n    = 1'b1;
        w_busy_n  = 1'b0;
        w_done_n  = 1'b0;
        w_bit_end = (r_cnt == C_CNT_LAST);

        if (r_state != S_IDLE) begin
            w_cnt_n = w_bit_end ? '0 : r_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_state_n = S_START;
                    w_shift_n = data;
                    // Parity is fixed at capture time from the latched word.
                    w_par_n   = (PARITY == 1) ? ~(^data) : (^data);
                    w_cnt_n   = '0;
                    w_idx_n   = '0;
                    w_stop_n  = 1'b0;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_n = S_DATA;
                    w_idx_n   = '0;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    if (r_idx == C_IDX_LAST) begin
                        w_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        w_stop_n  = 1'b0;
                    end else begin
                        w_idx_n   = r_idx + 1'b1;
                        w_shift_n = r_shift >> 1;
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_n = S_STOP;
                    w_stop_n  = 1'b0;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    if (r_stop == C_STOP_LAST) begin
                        w_state_n = S_IDLE;
                    end else begin
                        w_stop_n = 1'b1;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shift_n[0];
            S_PARITY: w_tx_n = w_par_n;
            default:  w_tx_n = 1'b1;
        endcase

        w_busy_n = (w_state_n != S_IDLE);
        // done marks the final clock of the final stop bit.
        w_done_n = (w_state_n == S_STOP) && (w_stop_n == C_STOP_LAST) &&
                   (w_cnt_n == C_CNT_LAST);
    end

    // State, datapath and output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_stop  <= 1'b0;
            r_shift <= '0;
            r_par   <= 1'b0;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_idx   <= w_idx_n;
            r_stop  <= w_stop_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            tx      <= w_tx_n;
            busy    <= w_busy_n;
            done    <= w_done_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_param
//  Description : Scoreboard bench for uart_tx_param. Three instances cover
//                even parity / 1 clk per bit, odd parity / 4 clks per bit and
//                no parity / 7 data bits / 2 stop bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_param;

    typedef struct packed {
        logic [8:0] word;
        int         start;
    } exp_t;

    logic       clk = 1'b0;
    logic [2:0] send_v;
    logic [2:0] rst_v;
    logic [8:0] data_v [3];
    wire  [2:0] tx_v;
    wire  [2:0] busy_v;
    wire  [2:0] done_v;

    int cyc   = 0;
    int n_cmp = 0;
    int n_err = 0;

    int db_c  [3] = '{8, 8, 7};
    int cpb_c [3] = '{1, 4, 1};
    int par_c [3] = '{2, 1, 0};
    int stp_c [3] = '{1, 1, 2};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .send(send_v[0]), .data(data_v[0][7:0]),
        .tx(tx_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk(clk), .rst(rst_v[1]), .send(send_v[1]), .data(data_v[1][7:0]),
        .tx(tx_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst_v[2]), .send(send_v[2]), .data(data_v[2][6:0]),
        .tx(tx_v[2]), .busy(busy_v[2]), .done(done_v[2])
    );

    // ---------------- reference model helpers ----------------
    function automatic int flen(input int id);
        return (1 + db_c[id] + ((par_c[id] != 0) ? 1 : 0) + stp_c[id]) * cpb_c[id];
    endfunction

    function automatic logic [8:0] mask(input int id);
        return 9'((1 << db_c[id]) - 1);
    endfunction

    // Serial bit k of a frame: start, data LSB first, parity, then stop bits.
    function automatic logic exp_bit(input int id, input logic [8:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= db_c[id]) return w[k-1];
        if ((par_c[id] != 0) && (k == db_c[id] + 1)) return (par_c[id] == 2) ? (^w) : ~(^w);
        return 1'b1;
    endfunction

    function automatic void q_push(input int id, input exp_t e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int q_size(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int id);
        case (id)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void q_drop(input int id);
        exp_t tmp;
        case (id)
            0:       tmp = q0.pop_front();
            1:       tmp = q1.pop_front();
            default: tmp = q2.pop_front();
        endcase
    endfunction

    task automatic chk(input string nm, input int id, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d cyc=%0d actual=%h required=%h", nm, id, cyc, act, exp);
        end
    endtask

    // Request acceptance model: a request is taken when the transmitter is idle,
    // reset frees it for the following cycle.
    task automatic model(input int id);
        int   free;
        exp_t e;
        free = 0;
        forever begin
            @(posedge clk);
            if (rst_v[id]) begin
                free = cyc + 1;
            end else if (send_v[id] && (cyc >= free)) begin
                e.word  = data_v[id] & mask(id);
                e.start = cyc + 1;
                q_push(id, e);
                free = cyc + 1 + flen(id);
            end
        end
    endtask

    // Monitor: checks idle line or an expected frame cycle by cycle and decodes mid-bit.
    task automatic monitor(input int id);
        exp_t       e;
        logic [8:0] rx;
        int         len;
        int         k;
        bit         aborted;
        len = flen(id);
        e   = '0;
        forever begin
            @(negedge clk);
            if (q_size(id) != 0) e = q_front(id);
            if ((q_size(id) != 0) && (e.start == cyc)) begin
                q_drop(id);
                rx      = '0;
                aborted = 1'b0;
                for (int c = 0; c < len; c++) begin
                    if (c != 0) @(negedge clk);
                    k = c / cpb_c[id];
                    chk("frame_tx",   id, 9'(tx_v[id]),   9'(exp_bit(id, e.word, k)));
                    chk("frame_busy", id, 9'(busy_v[id]), 9'd1);
                    chk("frame_done", id, 9'(done_v[id]), 9'(c == len - 1));
                    if ((k >= 1) && (k <= db_c[id]) && ((c % cpb_c[id]) == cpb_c[id] / 2))
                        rx[k-1] = tx_v[id];
                    if (rst_v[id]) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted) chk("rx_word", id, rx, e.word);
            end else begin
                chk("idle_tx",   id, 9'(tx_v[id]),   9'd1);
                chk("idle_busy", id, 9'(busy_v[id]), 9'd0);
                chk("idle_done", id, 9'(done_v[id]), 9'd0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int id, input logic [8:0] d);
        data_v[id] = d;
        send_v[id] = 1'b1;
        step(1);
        send_v[id] = 1'b0;
    endtask

    task automatic run_dut(input int id);
        int         len;
        logic [8:0] w [5];
        len  = flen(id);
        w[0] = 9'h0A3;
        w[1] = 9'h000;
        w[2] = 9'h0FF;
        w[3] = 9'($urandom);
        w[4] = 9'($urandom);

        // Directed word plus the all-ones word for the narrow configuration.
        pulse(id, 9'h055);
        step(len + 2);
        pulse(id, 9'h07F);
        step(len + 2);

        // Random single requests, data noise mid-frame and an ignored send while busy.
        repeat (6) begin
            pulse(id, 9'($urandom));
            for (int c = 0; c < len - 1; c++) begin
                data_v[id] = 9'($urandom);
                send_v[id] = (c == len / 2) ? 1'($urandom_range(0, 1)) : 1'b0;
                step(1);
            end
            send_v[id] = 1'b0;
            step(1 + $urandom_range(0, 3));
        end

        // send held high: back-to-back frames separated by one idle cycle.
        send_v[id] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_v[id] = w[i];
            step(1);
            for (int c = 0; c < len; c++) begin
                data_v[id] = 9'($urandom);
                step(1);
            end
        end
        send_v[id] = 1'b0;
        step(len + 2);

        // Reset inside data bit 3, then a clean frame.
        pulse(id, 9'($urandom));
        step(4 * cpb_c[id] + ((cpb_c[id] > 1) ? 1 : 0));
        rst_v[id] = 1'b1;
        step(1);
        rst_v[id] = 1'b0;
        step(2);
        pulse(id, 9'($urandom));
        step(len + 3);
    endtask

    initial begin
        send_v = '0;
        rst_v  = 3'b111;
        for (int i = 0; i < 3; i++) data_v[i] = '0;
        fork
            model(0);
            model(1);
            model(2);
        join_none
        step(3);
        rst_v = '0;
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        step(2);
        for (int id = 0; id < 3; id++) run_dut(id);
        step(3);
        for (int id = 0; id < 3; id++) chk("sb_empty", id, 9'(q_size(id)), 9'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
